// File: rtl/iq_downmixer_pkg.sv
// iq_downmixer_pkg
// Shared definitions for the IQ downmixer:
//   quad_t      - NCO quadrant taken from the top two phase bits
//   acc_width() - signed output/accumulator width for a given input width
//                 and decimation factor (IN_W + 1 + clog2(DECIM))
package iq_downmixer_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'b00,  // I +1, Q -1
        QUAD_1 = 2'b01,  // I -1, Q -1
        QUAD_2 = 2'b10,  // I -1, Q +1
        QUAD_3 = 2'b11   // I +1, Q +1
    } quad_t;

    function automatic int acc_width(input int in_w, input int decim);
        return in_w + 1 + $clog2(decim);
    endfunction

endpackage

// File: rtl/iq_nco.sv
// iq_nco
// Phase accumulator with quadrant decode into I/Q sign selects.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr        - synchronous phase restart (wins over advance)
//   advance    - add freq_word to the phase this cycle
//   freq_word  - phase increment (PHASE_W bits)
//   i_neg      - current quadrant multiplies I by -1
//   q_neg      - current quadrant multiplies Q by -1
module iq_nco
    import iq_downmixer_pkg::*;
#(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               advance,
    input  logic [PHASE_W-1:0] freq_word,
    output logic               i_neg,
    output logic               q_neg
);

    logic [PHASE_W-1:0] phase;
    quad_t              quad;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (advance) begin
            phase <= phase + freq_word;  // wraps modulo 2^PHASE_W
        end
    end

    assign quad = quad_t'(phase[PHASE_W-1 -: 2]);

    always_comb begin
        i_neg = 1'b0;
        q_neg = 1'b0;
        unique case (quad)
            QUAD_0: begin i_neg = 1'b0; q_neg = 1'b1; end
            QUAD_1: begin i_neg = 1'b1; q_neg = 1'b1; end
            QUAD_2: begin i_neg = 1'b1; q_neg = 1'b0; end
            QUAD_3: begin i_neg = 1'b0; q_neg = 1'b0; end
        endcase
    end

endmodule

// File: rtl/iq_downmixer.sv
// iq_downmixer
// Quarter-rate IQ downmixer with integrate-and-dump decimation by DECIM.
// Optional feature: define IQ_DOWNMIXER_DUMP_CNT_EN to add the dump_cnt output.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   freq_word         - NCO phase increment per accepted sample
//   phase_clr         - restart phase, sample count and accumulators
//   s_data/s_valid/s_ready - signed input sample stream
//   m_i/m_q/m_valid/m_ready - signed I/Q block sums, held until accepted
//   dump_cnt          - (optional) number of dumps modulo 2^16
module iq_downmixer
    import iq_downmixer_pkg::*;
#(
    parameter int IN_W    = 12,
    parameter int PHASE_W = 16,
    parameter int DECIM   = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [PHASE_W-1:0]                       freq_word,
    input  logic                                     phase_clr,
    input  logic signed [IN_W-1:0]                   s_data,
    input  logic                                     s_valid,
    output logic                                     s_ready,
    output logic signed [acc_width(IN_W, DECIM)-1:0] m_i,
    output logic signed [acc_width(IN_W, DECIM)-1:0] m_q,
    output logic                                     m_valid,
    input  logic                                     m_ready
`ifdef IQ_DOWNMIXER_DUMP_CNT_EN
    ,
    output logic [15:0]                              dump_cnt
`endif
);

    localparam int ACC_W  = acc_width(IN_W, DECIM);
    localparam int CNT_W  = $clog2(DECIM);
    localparam int PROD_W = IN_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0]         count;
    logic signed [ACC_W-1:0]  acc_i, acc_q, sum_i, sum_q;
    logic signed [PROD_W-1:0] sample_x, prod_i, prod_q;
    logic                     i_neg, q_neg;
    logic                     last, stall, accept, dump;

    // Only the block-completing sample can be blocked: it is the one that
    // would overwrite an output the sink has not taken yet.
    assign last    = (count == LAST);
    assign stall   = last && m_valid && !m_ready;
    assign s_ready = !rst && !phase_clr && !stall;
    assign accept  = s_valid && s_ready;
    assign dump    = accept && last;

    iq_nco #(.PHASE_W(PHASE_W)) u_nco (
        .clk       (clk),
        .rst       (rst),
        .clr       (phase_clr),
        .advance   (accept),
        .freq_word (freq_word),
        .i_neg     (i_neg),
        .q_neg     (q_neg)
    );

    // One extra bit so that negating the most negative sample cannot wrap.
    assign sample_x = {s_data[IN_W-1], s_data};
    assign prod_i   = i_neg ? -sample_x : sample_x;
    assign prod_q   = q_neg ? -sample_x : sample_x;
    assign sum_i    = acc_i + ACC_W'(prod_i);
    assign sum_q    = acc_q + ACC_W'(prod_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            acc_i   <= '0;
            acc_q   <= '0;
            m_i     <= '0;
            m_q     <= '0;
            m_valid <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (phase_clr) begin
                count <= '0;
                acc_i <= '0;
                acc_q <= '0;
            end else if (accept) begin
                if (last) begin
                    // Dump includes the current sample; next block starts clean.
                    count   <= '0;
                    acc_i   <= '0;
                    acc_q   <= '0;
                    m_i     <= sum_i;
                    m_q     <= sum_q;
                    m_valid <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end
        end
    end

`ifdef IQ_DOWNMIXER_DUMP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dump_cnt <= '0;
        end else if (dump) begin
            dump_cnt <= dump_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iq_downmixer.sv
// tb_iq_downmixer
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the mixer (integer phase, per-block integer sums).
module tb_iq_downmixer;

    localparam int IN_W    = 12;
    localparam int PHASE_W = 16;
    localparam int DECIM   = 8;
    localparam int ACC_W   = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [PHASE_W-1:0]       freq_word;
    logic                     phase_clr;
    logic signed [IN_W-1:0]   s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [ACC_W-1:0]  m_i;
    logic signed [ACC_W-1:0]  m_q;
    logic                     m_valid;
    logic                     m_ready;
`ifdef IQ_DOWNMIXER_DUMP_CNT_EN
    logic [15:0]              dump_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mdl_phase, mdl_cnt, mdl_sum_i, mdl_sum_q;
    int mdl_pend, mdl_out_i, mdl_out_q, mdl_dumps;
    int last_i, last_q;

    iq_downmixer #(.IN_W(IN_W), .PHASE_W(PHASE_W), .DECIM(DECIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .freq_word (freq_word),
        .phase_clr (phase_clr),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_i       (m_i),
        .m_q       (m_q),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
`ifdef IQ_DOWNMIXER_DUMP_CNT_EN
        ,
        .dump_cnt  (dump_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_phase = 0; mdl_cnt = 0; mdl_sum_i = 0; mdl_sum_q = 0;
        mdl_pend = 0; mdl_out_i = 0; mdl_out_q = 0; mdl_dumps = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; s_valid = 1'b1; s_data = 12'sd100; m_ready = 1'b0;
        phase_clr = 1'b0; freq_word = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check("rst_m_valid", m_valid, 0);
            check("rst_m_i", m_i, 0);
            check("rst_m_q", m_q, 0);
            check("rst_s_ready", s_ready, 0);
        end
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_release_s_ready", s_ready, 1);
    endtask

    // One clock cycle: apply inputs, compare against the model, then let
    // the model take the same clock edge.
    task automatic cycle(input logic v, input logic signed [IN_W-1:0] d,
                         input logic r, input logic c,
                         input logic [PHASE_W-1:0] fw, output logic rdy_obs);
        logic exp_rdy, acc;
        int   qd, pi, pq;
        s_valid = v; s_data = d; m_ready = r; phase_clr = c; freq_word = fw;
        #1;
        exp_rdy = !c && !(mdl_cnt == DECIM - 1 && mdl_pend != 0 && !r);
        rdy_obs = s_ready;
        check("s_ready", s_ready, exp_rdy);
        check("m_valid", m_valid, mdl_pend);
        if (mdl_pend != 0) begin
            check("m_i", m_i, mdl_out_i);
            check("m_q", m_q, mdl_out_q);
        end
`ifdef IQ_DOWNMIXER_DUMP_CNT_EN
        check("dump_cnt", dump_cnt, mdl_dumps % 65536);
`endif
        acc = v && exp_rdy;
        if (mdl_pend != 0 && r) begin
            mdl_pend = 0;
            last_i = int'(m_i);
            last_q = int'(m_q);
        end
        if (c) begin
            mdl_phase = 0; mdl_cnt = 0; mdl_sum_i = 0; mdl_sum_q = 0;
        end else if (acc) begin
            qd = mdl_phase / (1 << (PHASE_W - 2));
            pi = (qd == 0 || qd == 3) ? int'(d) : -int'(d);
            pq = (qd < 2) ? -int'(d) : int'(d);
            mdl_sum_i += pi;
            mdl_sum_q += pq;
            mdl_phase = (mdl_phase + int'(fw)) % (1 << PHASE_W);
            mdl_cnt++;
            if (mdl_cnt == DECIM) begin
                mdl_pend = 1; mdl_out_i = mdl_sum_i; mdl_out_q = mdl_sum_q;
                mdl_sum_i = 0; mdl_sum_q = 0; mdl_cnt = 0; mdl_dumps++;
            end
        end
        @(posedge clk); #1;
    endtask

    // DECIM accepted samples of constant data, then check the dumped block.
    task automatic run_block(input logic signed [IN_W-1:0] d,
                             input logic [PHASE_W-1:0] fw,
                             input int exp_i, input int exp_q, input string tag);
        logic rdy;
        for (int k = 0; k < DECIM; k++) cycle(1'b1, d, 1'b1, 1'b0, fw, rdy);
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_i"}, m_i, exp_i);
        check({tag, "_q"}, m_q, exp_q);
    endtask

    initial begin
        logic rdy;
        model_reset();
        last_i = 0; last_q = 0;
        do_reset(2);

        // Zero frequency: quadrant 0, I +1, Q -1
        run_block(12'sd100, 16'h0000, 800, -800, "f0_block");
        cycle(1'b0, 12'sd0, 1'b1, 1'b0, 16'h0000, rdy);

        // Quarter-rate: each block spans two full cycles of the quadrant sequence
        run_block(12'sd100, 16'h4000, 0, 0, "fq_block1");
        run_block(12'sd100, 16'h4000, 0, 0, "fq_block2");
        cycle(1'b0, 12'sd0, 1'b1, 1'b0, 16'h0000, rdy);

        // Most negative input, no wrap
        run_block(-12'sd2048, 16'h0000, -16384, 16384, "minval_block");
        cycle(1'b0, 12'sd0, 1'b1, 1'b0, 16'h0000, rdy);

        // Backpressure: second block's last sample stalls until m_ready
        for (int k = 0; k < 8; k++) cycle(1'b1, 12'sd100, 1'b0, 1'b0, 16'h0000, rdy);
        for (int k = 0; k < 7; k++) cycle(1'b1, 12'sd50, 1'b0, 1'b0, 16'h0000, rdy);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 12'sd50, 1'b0, 1'b0, 16'h0000, rdy);
            check("bp_stall_ready", rdy, 0);
        end
        cycle(1'b1, 12'sd50, 1'b1, 1'b0, 16'h0000, rdy);
        check("bp_release_ready", rdy, 1);
        check("bp_first_i", last_i, 800);
        check("bp_first_q", last_q, -800);
        cycle(1'b0, 12'sd0, 1'b1, 1'b0, 16'h0000, rdy);
        check("bp_second_i", last_i, 400);
        check("bp_second_q", last_q, -400);

        // phase_clr after three accepts restarts the block
        for (int k = 0; k < 3; k++) cycle(1'b1, 12'sd100, 1'b1, 1'b0, 16'h0000, rdy);
        cycle(1'b1, 12'sd100, 1'b1, 1'b1, 16'h0000, rdy);
        check("clr_ready", rdy, 0);
        run_block(12'sd100, 16'h0000, 800, -800, "clr_block");
        cycle(1'b0, 12'sd0, 1'b1, 1'b0, 16'h0000, rdy);

        // Randomized traffic with occasional clears and mid-block resets
        begin
            logic [PHASE_W-1:0] fw;
            fw = PHASE_W'($urandom);
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 63) == 0) fw = PHASE_W'($urandom);
                if ($urandom_range(0, 499) == 0) begin
                    do_reset(1);
                end else begin
                    cycle($urandom_range(0, 3) != 0, IN_W'($urandom),
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 59) == 0, fw, rdy);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_downmixer.md
IQ_DOWNMIXER -- requirements
Module: iq_downmixer

Interface
REQ-001 SHALL have parameter IN_W, default 12, signed input sample width.
REQ-002 SHALL have parameter PHASE_W, default 16, NCO phase accumulator width.
REQ-003 SHALL have parameter DECIM, default 8, samples per output (power of two, 2..256).
REQ-004 SHALL derive ACC_W = IN_W + 1 + clog2(DECIM), signed output width (16 at defaults).
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port freq_word  in  PHASE_W  phase increment per accepted sample.
REQ-007 SHALL have port phase_clr  in  1  synchronous restart of phase, count and accumulators.
REQ-008 SHALL have ports s_data  in  IN_W  signed sample; s_valid  in  1; s_ready  out  1.
REQ-009 SHALL have ports m_i  out  ACC_W  signed I sum; m_q  out  ACC_W  signed Q sum; m_valid  out  1; m_ready  in  1.

Function
REQ-010 SHALL accept a sample only on a cycle with s_valid=1 and s_ready=1.
REQ-011 SHALL use current phase top two bits p[1:0] for each accepted sample: I multiplier +1 for p=00/11, -1 for 01/10; Q multiplier -1 for p=00/01, +1 for 10/11.
REQ-012 SHALL form products at IN_W+1 bits so that negating -2^(IN_W-1) does not overflow.
REQ-013 SHALL advance phase by freq_word modulo 2^PHASE_W after each accepted sample; freq_word takes effect on the next accepted sample.
REQ-014 SHALL accumulate I and Q products over DECIM accepted samples, then dump: the sum including the DECIM-th sample loads m_i/m_q with m_valid=1 on the next cycle, and the accumulators restart from zero with no lost sample.
REQ-015 SHALL hold m_i, m_q and m_valid stable until m_valid=1 and m_ready=1; m_valid then clears unless a dump loads a new result on the same cycle.
REQ-016 SHALL drive s_ready=0 only when the sample count equals DECIM-1, m_valid=1 and m_ready=0; there is no overrun and no sample drop.
REQ-017 SHALL on phase_clr=1 zero the phase, count and accumulators; any sample presented that cycle is discarded (s_ready=0); a pending output is preserved.
REQ-018 SHALL treat phase_clr on the dump cycle as winning: no dump occurs.

Reset
REQ-019 SHALL on rst=1 set phase=0, count=0, accumulators=0, m_valid=0, m_i=0, m_q=0, s_ready=0; s_ready=1 from the first cycle after rst drops.
REQ-020 SHALL let a mid-block reset discard the partial block and any pending output.

Configuration
REQ-021 SHALL provide macro IQ_DOWNMIXER_DUMP_CNT_EN; when defined, add output dump_cnt (16 bits), incremented by 1 mod 2^16 on each dump, cleared by rst (not by phase_clr); when undefined, the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-022 SHALL place the quadrant encoding constants and the clog2-based ACC_W helper in shared package iq_downmixer_pkg.
REQ-023 SHALL implement the phase accumulator and quadrant decode as one sub-module, iq_nco, with the rest in iq_downmixer.

Verification
REQ-024 SHALL cover reset: check m_valid=0, m_i=m_q=0 and s_ready=0 during rst, and s_ready=1 on the cycle after rst drops.
REQ-025 SHALL cover freq_word=0 with eight samples of s_data=100 at continuous valid: m_i=800, m_q=-800, with m_valid rising one cycle after the 8th accept.
REQ-026 SHALL cover freq_word=0x4000 with a constant s_data=100: m_i=0, m_q=0 for every block.
REQ-027 SHALL cover freq_word=0 with a constant s_data=-2048: m_i=-16384, m_q=16384, with no wrap.
REQ-028 SHALL cover m_ready=0 with 16 samples offered: s_ready falls on the 16th sample until m_ready=1; both results then emerge in order with correct sums.
REQ-029 SHALL cover phase_clr pulsed after 3 accepts of s_data=100 (freq_word=0): the next output is m_i=800, built from exactly 8 post-clear samples.
